// File: rtl/alu_issue_stage.sv
// ALU issue stage: registers one operation per cycle into S1, drives an external
// combinational ALU from it and queues the response in an in-order result FIFO.
module alu_issue_stage #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_command,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_operandA,
    output logic [31:0]      alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [31:0]      alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      ovf_count,
    input  logic             ovf_clr
);

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } cmd_e;

    localparam logic [1:0] DEPTH_P   = 2'(DEPTH);
    localparam logic [2:0] DEPTH_OCC = 3'(DEPTH);

    logic             s1_valid;
    cmd_e             s1_cmd;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic [31:0]      fifo_result [DEPTH];
    logic [3:0]       fifo_flags  [DEPTH];
    logic [TAG_W-1:0] fifo_tag    [DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       count;

    logic [2:0]       occupancy;
    logic             in_xfer;
    logic             capture;
    logic             pop;
    logic             slt_bit;
    logic [3:0]       cap_flags;
    logic             ovf_event;
    logic [31:0]      head_result;
    logic [3:0]       head_flags;
    logic [TAG_W-1:0] head_tag;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == DEPTH_P - 2'd1) ? 2'd0 : ptr + 2'd1;
    endfunction

    // S1 and the FIFO share the DEPTH slots, so S1 can always be captured next edge
    assign occupancy = {1'b0, count} + {2'b00, s1_valid};
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = (occupancy < DEPTH_OCC) || (pop && (occupancy == DEPTH_OCC));
    assign in_xfer   = in_valid && in_ready;
    assign capture   = s1_valid;

    assign alu_operandA = s1_valid ? s1_a   : '0;
    assign alu_operandB = s1_valid ? s1_b   : '0;
    assign alu_command  = s1_valid ? s1_cmd : 3'b000;

    assign slt_bit   = (s1_cmd == CMD_SLT) && alu_result[0];
    assign cap_flags = {alu_carryout, alu_zero, alu_overflow, slt_bit};
    assign ovf_event = capture && alu_overflow && ((s1_cmd == CMD_ADD) || (s1_cmd == CMD_SUB));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_cmd   <= CMD_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_cmd   <= cmd_e'(in_command);
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
        end else begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) wr_ptr <= next_ptr(wr_ptr);
            if (pop)     rd_ptr <= next_ptr(rd_ptr);
            case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_ptr == 2'(i)) begin
                    fifo_result[i] <= alu_result;
                    fifo_flags[i]  <= cap_flags;
                    fifo_tag[i]    <= s1_tag;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (ovf_event && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

    always_comb begin
        head_result = '0;
        head_flags  = '0;
        head_tag    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_ptr == 2'(i)) begin
                head_result = fifo_result[i];
                head_flags  = fifo_flags[i];
                head_tag    = fifo_tag[i];
            end
        end
    end

    assign out_result = out_valid ? head_result : '0;
    assign out_flags  = out_valid ? head_flags  : '0;
    assign out_tag    = out_valid ? head_tag    : '0;

    no_fifo_overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(capture && (count == DEPTH_P) && !pop));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: provides a golden combinational ALU and checks every
// presented result against a transaction-level queue model.
module tb_alu_issue_stage;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid, in_ready;
    logic [2:0]       in_command;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      alu_operandA, alu_operandB, alu_result;
    logic [2:0]       alu_command;
    logic             alu_carryout, alu_zero, alu_overflow;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      ovf_count;
    logic             ovf_clr;

    always #5 clk = ~clk;

    alu_issue_stage #(.TAG_W(TAG_W), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
        .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_tag(out_tag),
        .ovf_count(ovf_count), .ovf_clr(ovf_clr)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } alu_t;

    typedef struct packed {
        logic [31:0]      res;
        logic [3:0]       flags;
        logic [TAG_W-1:0] tag;
        logic [2:0]       cmd;
        logic [31:0]      a;
        logic [31:0]      b;
        logic             ovf_inc;
        int               acc;
    } exp_t;

    function automatic alu_t golden(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        alu_t r;
        logic [32:0] w;
        r = '0;
        case (cmd)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r.res = w[31:0]; r.c = w[32];
                r.v = (a[31] == b[31]) && (r.res[31] != a[31]);
            end
            3'd1: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.res = w[31:0]; r.c = w[32];
                r.v = (a[31] != b[31]) && (r.res[31] != a[31]);
            end
            3'd2: r.res = a ^ b;
            3'd3: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r.res = a & b;
            3'd5: r.res = ~(a & b);
            3'd6: r.res = ~(a | b);
            default: r.res = a | b;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    function automatic exp_t make_exp(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                      input logic [TAG_W-1:0] tag, input int acc);
        exp_t e;
        alu_t r;
        r = golden(cmd, a, b);
        e.res     = r.res;
        e.flags   = {r.c, r.z, r.v, (cmd == 3'd3) ? r.res[0] : 1'b0};
        e.tag     = tag;
        e.cmd     = cmd;
        e.a       = a;
        e.b       = b;
        e.ovf_inc = ((cmd == 3'd0) || (cmd == 3'd1)) && r.v;
        e.acc     = acc;
        return e;
    endfunction

    alu_t alu_r;
    always_comb alu_r = golden(alu_command, alu_operandA, alu_operandB);
    assign alu_result   = alu_r.res;
    assign alu_carryout = alu_r.c;
    assign alu_zero     = alu_r.z;
    assign alu_overflow = alu_r.v;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // transaction-level model: every accepted op is visible one edge after its
    // accepting edge and leaves in acceptance order
    exp_t        q[$];
    int          edge_cnt = 0;
    int          acc_cnt  = 0;
    int          dut_pops = 0;
    logic [15:0] ovf_exp  = '0;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin : scoreboard
        exp_t e;
        exp_t es1;
        logic exp_ov, exp_rdy, s1_busy;
        if (reset) begin
            q.delete();
            ovf_exp = '0;
            check("rst_out", {out_valid, out_result, out_flags, out_tag}, '0);
            check("rst_alu", {alu_command, alu_operandA, alu_operandB}, '0);
            check("rst_ovf", ovf_count, '0);
        end else begin
            exp_ov  = (q.size() > 0) && (edge_cnt >= q[0].acc + 1);
            s1_busy = (q.size() > 0) && (q[q.size()-1].acc == edge_cnt);
            es1     = (q.size() > 0) ? q[q.size()-1] : '0;
            exp_rdy = (q.size() < 2) || ((q.size() == 2) && exp_ov && out_ready);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_rdy);
            check("ovf_count", ovf_count, ovf_exp);
            if (s1_busy)
                check("alu_drive", {alu_command, alu_operandA, alu_operandB}, {es1.cmd, es1.a, es1.b});
            else
                check("alu_idle", {alu_command, alu_operandA, alu_operandB}, '0);
            if (exp_ov) begin
                e = q[0];
                check("out_data", {out_result, out_flags, out_tag}, {e.res, e.flags, e.tag});
                if (out_ready) void'(q.pop_front());
            end else begin
                check("out_idle", {out_result, out_flags, out_tag}, '0);
            end
            if (out_valid && out_ready) dut_pops++;
            if (ovf_clr) ovf_exp = '0;
            else if (s1_busy && es1.ovf_inc && ovf_exp != 16'hFFFF) ovf_exp = ovf_exp + 16'd1;
            if (in_valid && in_ready) begin
                q.push_back(make_exp(in_command, in_a, in_b, in_tag, edge_cnt + 1));
                acc_cnt++;
            end
        end
    end

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: rand_word = 32'h0000_0000;
            1: rand_word = 32'hFFFF_FFFF;
            2: rand_word = 32'h7FFF_FFFF;
            3: rand_word = 32'h8000_0000;
            4: rand_word = 32'h0000_0001;
            default: rand_word = $urandom;
        endcase
    endfunction

    // entered and left at posedge+1; returns just after the accepting edge
    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input bit rnd);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_command = c; in_a = a; in_b = b; in_tag = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
                ovf_clr   = ($urandom_range(0, 15) == 0);
            end
            if (ok) break;
        end
        check("send_accept", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pop0, acc0;

    initial begin
        in_valid = 1'b0; in_command = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_async_out", {out_valid, out_result, out_flags, out_tag}, '0);
        check("rst_async_alu", {alu_command, alu_operandA, alu_operandB}, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1'b1);
        tick();

        // ADD 5+7: visible two edges after offer
        send(3'd0, 32'd5, 32'd7, 5'h0A, 1'b0);
        tick();
        check("add_valid", out_valid, 1'b1);
        check("add_data", {out_result, out_flags, out_tag}, {32'd12, 4'b0000, 5'h0A});

        send(3'd1, 32'd3, 32'd3, 5'h11, 1'b0);
        tick();
        check("sub_result", out_result, 32'd0);
        check("sub_zero", out_flags[2], 1'b1);
        send(3'd3, 32'hFFFF_FFFF, 32'd1, 5'h12, 1'b0);
        tick();
        check("slt_result", out_result, 32'd1);
        check("slt_bit", out_flags[0], 1'b1);
        repeat (2) tick();

        // back-to-back with a stalled consumer
        pop0 = dut_pops; acc0 = acc_cnt;
        out_ready = 1'b0;
        send(3'd2, 32'hA5A5_0000, 32'h0000_5A5A, 5'h01, 1'b0);
        send(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'h02, 1'b0);
        in_valid = 1'b1; in_command = 3'd7; in_a = 32'h1; in_b = 32'h2; in_tag = 5'h03;
        @(negedge clk);
        check("stall_ready", in_ready, 1'b0);
        tick();
        @(negedge clk);
        check("stall_ready2", {in_ready, out_valid}, 2'b01);
        tick();
        out_ready = 1'b1;
        send(3'd7, 32'h1, 32'h2, 5'h03, 1'b0);
        send(3'd5, 32'hFFFF_0000, 32'hFF00_FF00, 5'h04, 1'b0);
        repeat (4) tick();
        check("b2b_pops", dut_pops - pop0, 4);
        check("b2b_accepts", acc_cnt - acc0, 4);

        // overflow counter saturation and clear priority
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        for (int i = 0; i < 65534; i++) send(3'd0, 32'h7FFF_FFFF, 32'd1, 5'(i), 1'b0);
        repeat (3) tick();
        check("ovf_near_sat", ovf_count, 16'hFFFE);
        for (int i = 0; i < 4; i++) send(3'd0, 32'h7FFF_FFFF, 32'd1, 5'h1F, 1'b0);
        repeat (3) tick();
        check("ovf_sat", ovf_count, 16'hFFFF);
        send(3'd0, 32'h7FFF_FFFF, 32'd1, 5'h05, 1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_prio", ovf_count, 16'h0000);
        send(3'd0, 32'd1, 32'd1, 5'h06, 1'b0);
        send(3'd1, 32'h8000_0000, 32'd1, 5'h07, 1'b0);
        send(3'd6, 32'h7FFF_FFFF, 32'h8000_0000, 5'h08, 1'b0);
        repeat (3) tick();
        check("ovf_after_clr", ovf_count, 16'h0001);

        // reset with S1 and buffer occupied
        out_ready = 1'b0;
        send(3'd0, 32'd10, 32'd20, 5'h09, 1'b0);
        send(3'd0, 32'd30, 32'd40, 5'h0B, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_out", {out_valid, out_result, out_tag}, '0);
        check("mid_rst_alu", {alu_command, alu_operandA, alu_operandB}, '0);
        tick();
        reset = 1'b0;
        pop0 = dut_pops;
        out_ready = 1'b1;
        send(3'd0, 32'd100, 32'd23, 5'h0C, 1'b0);
        tick();
        check("post_rst_data", {out_valid, out_result, out_tag}, {1'b1, 32'd123, 5'h0C});
        tick();
        check("post_rst_alone", out_valid, 1'b0);
        check("post_rst_pops", dut_pops - pop0, 1);

        // randomized traffic
        pop0 = dut_pops; acc0 = acc_cnt;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(3'($urandom_range(0, 7)), rand_word(), rand_word(), 5'($urandom), 1'b1);
            end else begin
                tick();
                out_ready = ($urandom_range(0, 3) != 0);
                ovf_clr   = ($urandom_range(0, 15) == 0);
            end
        end
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (5) tick();
        check("rand_pops", dut_pops - pop0, acc_cnt - acc0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001: Parameter TAG_W, default 5, width of the destination-register tag carried alongside each operation.
REQ-002: Parameter DEPTH, default 2, number of entries in the result buffer; fixed at 2 for this revision.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: in_valid  input  1  upstream offers an operation this cycle.
REQ-006: in_ready  output  1  block accepts the operation this cycle.
REQ-007: in_command  input  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-008: in_a, in_b  input  32 each  operands.
REQ-009: in_tag  input  TAG_W  destination tag, passed through unmodified.
REQ-010: alu_operandA, alu_operandB  output  32 each  operands driven to the combinational ALU.
REQ-011: alu_command  output  3  command driven to the ALU.
REQ-012: alu_result  input  32; alu_carryout, alu_zero, alu_overflow  input  1 each  combinational ALU response, same cycle.
REQ-013: out_valid  output  1  result entry available.
REQ-014: out_ready  input  1  downstream consumes the entry this cycle.
REQ-015: out_result  output  32; out_flags  output  4 = {carryout, zero, overflow, slt_bit}; out_tag  output  TAG_W.
REQ-016: ovf_count  output  16  saturating count of ADD/SUB overflows; ovf_clr  input  1  synchronous clear.

Function
REQ-017: Handshake: transfer occurs on a rising edge where valid and ready are both 1; valid and payload shall be held stable by the sender until transfer.
REQ-018: Issue register S1 (valid bit, command, a, b, tag) shall load on input transfer; S1 drives alu_* outputs directly.
REQ-019: When S1 is invalid, alu_operandA, alu_operandB and alu_command shall be 0.
REQ-020: On the edge following S1 load, S1 shall be captured into the result buffer as result, flags and tag, and S1 shall clear unless a new input transfer reloads it on the same edge.
REQ-021: Latency: input accepted on edge N -> out_valid high in the cycle after edge N+1; throughput one operation per cycle with out_ready held high.
REQ-022: in_ready = 1 when (buffer count + S1 valid) < DEPTH, or when out_ready is 1 and out_valid is 1 and (buffer count + S1 valid) = DEPTH; never combinationally dependent on in_valid.
REQ-023: Result buffer is a FIFO with 2-bit read/write pointers wrapping modulo DEPTH; out_* present the head entry; outputs are order-preserving.
REQ-024: Simultaneous capture and pop: count unchanged, both pointers advance.
REQ-025: Buffer shall never overflow; a capture into a full buffer is a design error flagged by an assertion.
REQ-026: slt_bit = alu_result[0] when the command is SLT, else 0.
REQ-027: ovf_count increments by 1 on each capture with command ADD or SUB and alu_overflow = 1; it saturates at 16'hFFFF; other commands never change it.
REQ-028: ovf_clr = 1 sets ovf_count to 0 on the edge; clear takes priority over a simultaneous increment.
REQ-029: out_result, out_flags and out_tag shall be 0 when out_valid is 0.

Reset
REQ-030: reset = 1 shall immediately clear the S1 valid bit, pointers, count and ovf_count, and drive out_valid = 0 and all alu_* and out_* outputs to 0.
REQ-031: In-flight operations at reset are discarded without being presented.
REQ-032: in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-033: ADD a=5, b=7, out_ready=1 -> two cycles later out_result=12, out_flags=4'b0000, tag echoed.
REQ-034: SUB a=3, b=3 -> out_result=0, zero=1; SLT a=-1 (32'hFFFFFFFF), b=1 -> out_result=1, slt_bit=1.
REQ-035: Back-to-back 4 ops with out_ready=0 -> in_ready falls after 2 accepted; raise out_ready -> all 4 emerge in order, none lost or duplicated.
REQ-036: ADD 32'h7FFFFFFF + 1 repeated with ovf_count preset near 16'hFFFF -> count saturates at 16'hFFFF; ovf_clr with a simultaneous overflow -> count = 0.
REQ-037: Assert reset while S1 and buffer are full -> out_valid=0 immediately; after release, the next op emerges alone with correct result.
REQ-038: Random valid/ready stimulus against a golden ALU model -> every result, flag set and tag matches, order preserved.
